// File: rtl/piso_serializer_amisha_pkg.sv
// piso_pkg_amisha: shared definitions for the PISO serializer slice.
//   - piso_state_t   : FSM state encoding (IDLE / SHIFT / PARITY)
//   - PISO_WIDTH_DEFAULT : default parallel word width
//   - clog2_f        : ceiling log2 used to size the bit counter
// PARITY is only reachable when PISO_PARITY_EN is defined.
package piso_pkg_amisha;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SHIFT  = 2'b01,
    PARITY = 2'b10
  } piso_state_t;

  localparam int PISO_WIDTH_DEFAULT = 32'sd8;

  // Ceiling log2, never below 1 so a counter always has at least one bit.
  function automatic int clog2_f(input int value);
    int bits;
    int span;
    bits = 32'sd0;
    span = 32'sd1;
    while (span < value) begin
      span = span * 32'sd2;
      bits = bits + 32'sd1;
    end
    if (bits < 32'sd1) begin
      bits = 32'sd1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/piso_serializer_amisha_cnt.sv
// bit_cnt_amisha: clearable, enabled up-counter that indexes the bit being
// presented by the serializer. tc is high while the count equals WIDTH-1.
// The count saturates at WIDTH-1, so it never wraps inside a frame.
// Ports:
//   clk_amisha      clock
//   reset_n_amisha  asynchronous active-low reset
//   clr             synchronous clear (takes priority over en)
//   en              advance by one
//   tc              terminal count (count == WIDTH-1)
module bit_cnt_amisha
  import piso_pkg_amisha::*;
#(
  parameter int WIDTH = PISO_WIDTH_DEFAULT
) (
  input  logic clk_amisha,
  input  logic reset_n_amisha,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CNT_W = clog2_f(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(32'd0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] cnt_r;

  // Bit index register: clear on load, step on each accepted data bit.
  always_ff @(posedge clk_amisha or negedge reset_n_amisha) begin
    if (!reset_n_amisha) begin
      cnt_r <= CNT_ZERO;
    end else if (clr) begin
      cnt_r <= CNT_ZERO;
    end else if (en && (cnt_r != CNT_LAST)) begin
      cnt_r <= cnt_r + CNT_ONE;
    end
  end

  assign tc = (cnt_r == CNT_LAST);

endmodule

// File: rtl/piso_serializer_amisha.sv
// piso_serializer_amisha: parallel-in / serial-out stage. A word accepted on
// the load valid/ready port is shifted out one bit per serial handshake.
// Optional macro PISO_PARITY_EN appends an even-parity bit to every frame.
// Ports:
//   clk_amisha         clock (rising edge)
//   reset_n_amisha     asynchronous active-low reset
//   d_amisha           parallel word, sampled only on a load handshake
//   load_valid_amisha  upstream offers a word
//   load_ready_amisha  block is IDLE and can take a word (combinational)
//   ser_out_amisha     current serial bit (registered)
//   ser_valid_amisha   ser_out_amisha holds a valid bit (registered)
//   ser_ready_amisha   downstream accepts the current bit
//   busy_amisha        frame in progress (registered)
//   frame_done_amisha  one-cycle pulse in the first IDLE cycle after a frame
module piso_serializer_amisha
  import piso_pkg_amisha::*;
#(
  parameter int WIDTH     = PISO_WIDTH_DEFAULT,
  parameter int MSB_FIRST = 32'sd1
) (
  input  logic             clk_amisha,
  input  logic             reset_n_amisha,
  input  logic [WIDTH-1:0] d_amisha,
  input  logic             load_valid_amisha,
  output logic             load_ready_amisha,
  output logic             ser_out_amisha,
  output logic             ser_valid_amisha,
  input  logic             ser_ready_amisha,
  output logic             busy_amisha,
  output logic             frame_done_amisha
);

  localparam logic [WIDTH-1:0] WORD_ZERO = {WIDTH{1'b0}};

  piso_state_t      state_r;
  logic [WIDTH-1:0] shift_r;
  logic             ser_out_r;
  logic             ser_valid_r;
  logic             busy_r;
  logic             frame_done_r;
`ifdef PISO_PARITY_EN
  logic             parity_r;
`endif

  logic             load_ready_s;
  logic             load_fire_s;
  logic             bit_fire_s;
  logic             cnt_en_s;
  logic             cnt_tc_s;
  logic             first_bit_s;
  logic             next_bit_s;
  logic [WIDTH-1:0] shift_next_s;

  assign load_ready_s = (state_r == IDLE);
  assign load_fire_s  = load_valid_amisha & load_ready_s;
  // ser_ready is ignored unless a bit is actually being presented.
  assign bit_fire_s   = ser_valid_r & ser_ready_amisha;
  assign cnt_en_s     = bit_fire_s & (state_r == SHIFT) & ~cnt_tc_s;

  // Bit ordering: shift toward the output end so the next bit is always
  // one position inside the current one.
  assign first_bit_s  = (MSB_FIRST != 0) ? d_amisha[WIDTH-1] : d_amisha[0];
  assign next_bit_s   = (MSB_FIRST != 0) ? shift_r[WIDTH-2] : shift_r[1];
  assign shift_next_s = (MSB_FIRST != 0) ? {shift_r[WIDTH-2:0], 1'b0}
                                         : {1'b0, shift_r[WIDTH-1:1]};

  bit_cnt_amisha #(
    .WIDTH (WIDTH)
  ) u_bit_cnt (
    .clk_amisha     (clk_amisha),
    .reset_n_amisha (reset_n_amisha),
    .clr            (load_fire_s),
    .en             (cnt_en_s),
    .tc             (cnt_tc_s)
  );

  // Frame FSM with registered serial outputs.
  always_ff @(posedge clk_amisha or negedge reset_n_amisha) begin
    if (!reset_n_amisha) begin
      state_r      <= IDLE;
      shift_r      <= WORD_ZERO;
      ser_out_r    <= 1'b0;
      ser_valid_r  <= 1'b0;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
`ifdef PISO_PARITY_EN
      parity_r     <= 1'b0;
`endif
    end else begin
      frame_done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (load_fire_s) begin
            shift_r     <= d_amisha;
            ser_out_r   <= first_bit_s;
            ser_valid_r <= 1'b1;
            busy_r      <= 1'b1;
            state_r     <= SHIFT;
`ifdef PISO_PARITY_EN
            parity_r    <= ^d_amisha;
`endif
          end
        end
        SHIFT: begin
          if (bit_fire_s) begin
            if (cnt_tc_s) begin
`ifdef PISO_PARITY_EN
              // Last data bit taken: present the parity bit next.
              ser_out_r <= parity_r;
              state_r   <= PARITY;
`else
              ser_out_r    <= 1'b0;
              ser_valid_r  <= 1'b0;
              busy_r       <= 1'b0;
              frame_done_r <= 1'b1;
              state_r      <= IDLE;
`endif
            end else begin
              shift_r   <= shift_next_s;
              ser_out_r <= next_bit_s;
            end
          end
        end
`ifdef PISO_PARITY_EN
        PARITY: begin
          if (bit_fire_s) begin
            ser_out_r    <= 1'b0;
            ser_valid_r  <= 1'b0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b1;
            state_r      <= IDLE;
          end
        end
`endif
        default: begin
          // Unreachable encoding: fall back to a clean idle state.
          ser_out_r   <= 1'b0;
          ser_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign load_ready_amisha = load_ready_s;
  assign ser_out_amisha    = ser_out_r;
  assign ser_valid_amisha  = ser_valid_r;
  assign busy_amisha       = busy_r;
  assign frame_done_amisha = frame_done_r;

endmodule

// File: tb/tb_piso_serializer_amisha.sv
// Self-checking bench for piso_serializer_amisha: an MSB-first and an
// LSB-first instance (WIDTH=8) driven from a table of directed frames plus
// hand-written sequences for busy loads, back-to-back frames and reset.
module tb_piso_serializer_amisha;

`ifdef PISO_PARITY_EN
  localparam int PAR_EXTRA = 1;
`else
  localparam int PAR_EXTRA = 0;
`endif
  localparam int NB = 8 + PAR_EXTRA;

  logic       clk_amisha;
  logic       reset_n_amisha;
  logic [7:0] d;
  logic       load_valid;
  logic       ser_ready;
  logic       use_b;

  logic a_load_ready, a_out, a_valid, a_busy, a_done;
  logic b_load_ready, b_out, b_valid, b_busy, b_done;
  logic a_load_valid, b_load_valid;
  logic mon_load_ready, mon_out, mon_valid, mon_busy, mon_done;

  assign a_load_valid   = load_valid & ~use_b;
  assign b_load_valid   = load_valid & use_b;
  assign mon_load_ready = use_b ? b_load_ready : a_load_ready;
  assign mon_out        = use_b ? b_out        : a_out;
  assign mon_valid      = use_b ? b_valid      : a_valid;
  assign mon_busy       = use_b ? b_busy       : a_busy;
  assign mon_done       = use_b ? b_done       : a_done;

  piso_serializer_amisha #(.WIDTH(8), .MSB_FIRST(1)) dut_msb (
    .clk_amisha        (clk_amisha),
    .reset_n_amisha    (reset_n_amisha),
    .d_amisha          (d),
    .load_valid_amisha (a_load_valid),
    .load_ready_amisha (a_load_ready),
    .ser_out_amisha    (a_out),
    .ser_valid_amisha  (a_valid),
    .ser_ready_amisha  (ser_ready),
    .busy_amisha       (a_busy),
    .frame_done_amisha (a_done)
  );

  piso_serializer_amisha #(.WIDTH(8), .MSB_FIRST(0)) dut_lsb (
    .clk_amisha        (clk_amisha),
    .reset_n_amisha    (reset_n_amisha),
    .d_amisha          (d),
    .load_valid_amisha (b_load_valid),
    .load_ready_amisha (b_load_ready),
    .ser_out_amisha    (b_out),
    .ser_valid_amisha  (b_valid),
    .ser_ready_amisha  (ser_ready),
    .busy_amisha       (b_busy),
    .frame_done_amisha (b_done)
  );

  initial clk_amisha = 1'b0;
  always #5 clk_amisha = ~clk_amisha;

  int checks = 0;
  int errors = 0;

  // seq holds the expected wire order: seq[7] is the first bit sent.
  typedef struct {
    logic       use_b;
    logic [7:0] d;
    logic [7:0] seq;
    logic       par;
    int         stall_at;
    int         stall_len;
    int         cycles;
  } vec_t;

  vec_t vecs[5];

  task automatic tick();
    @(posedge clk_amisha);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic load_word(input logic [7:0] w);
    d          = w;
    load_valid = 1'b1;
    chk("load_ready_idle", mon_load_ready, 1);
    tick();
    load_valid = 1'b0;
    d          = 8'h00;
    chk("busy_after_load", mon_busy, 1);
    chk("load_ready_after_load", mon_load_ready, 0);
  endtask

  // Walks every bit of a frame; poke offers 8'h3C while busy and again on the last bit.
  task automatic shift_bits(input logic [7:0] seq, input logic par, input int stall_at,
                            input int stall_len, input bit poke, inout int cycles);
    for (int i = 0; i < NB; i++) begin
      logic expb;
      expb = (i < 8) ? seq[3'(7 - i)] : par;
      chk("ser_valid", mon_valid, 1);
      chk("ser_out", mon_out, expb);
      chk("load_ready_busy", mon_load_ready, 0);
      if (poke) begin
        if (i == 2) begin
          load_valid = 1'b1;
          d          = 8'h3C;
        end else if (i == 4) begin
          load_valid = 1'b0;
        end else if (i == NB - 1) begin
          load_valid = 1'b1;
          d          = 8'h3C;
        end
      end
      if (i == stall_at) begin
        ser_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          tick();
          cycles++;
          chk("stall_out", mon_out, expb);
          chk("stall_valid", mon_valid, 1);
        end
        ser_ready = 1'b1;
      end
      tick();
      cycles++;
    end
  endtask

  // Bounded wait for frame_done, then check the end-of-frame state.
  task automatic finish_frame(input int exp_cycles, inout int cycles);
    for (int k = 0; k < 20; k++) begin
      if (mon_done === 1'b1) break;
      tick();
      cycles++;
    end
    chk("frame_done_pulse", mon_done, 1);
    chk("frame_cycles", cycles, exp_cycles + PAR_EXTRA);
    chk("valid_after_frame", mon_valid, 0);
    chk("busy_after_frame", mon_busy, 0);
    chk("load_ready_after_frame", mon_load_ready, 1);
    tick();
    chk("frame_done_one_cycle", mon_done, 0);
  endtask

  initial begin
    int cyc;
    vecs[0] = '{1'b0, 8'hA5, 8'b10100101, 1'b0, -1, 0, 8};
    vecs[1] = '{1'b1, 8'h01, 8'b10000000, 1'b1, -1, 0, 8};
    vecs[2] = '{1'b0, 8'hA5, 8'b10100101, 1'b0,  3, 3, 11};
    vecs[3] = '{1'b0, 8'h07, 8'b00000111, 1'b1, -1, 0, 8};
    vecs[4] = '{1'b1, 8'h0E, 8'b01110000, 1'b1, -1, 0, 8};

    reset_n_amisha = 1'b0;
    d              = 8'h00;
    load_valid     = 1'b0;
    ser_ready      = 1'b1;
    use_b          = 1'b0;
    #12;
    chk("rst_load_ready_a", a_load_ready, 1);
    chk("rst_valid_a", a_valid, 0);
    chk("rst_out_a", a_out, 0);
    chk("rst_busy_a", a_busy, 0);
    chk("rst_done_a", a_done, 0);
    chk("rst_load_ready_b", b_load_ready, 1);
    chk("rst_valid_b", b_valid, 0);
    reset_n_amisha = 1'b1;
    tick();

    // ser_ready high with nothing to send must not move the block.
    for (int i = 0; i < 3; i++) begin
      chk("idle_ready_valid", mon_valid, 0);
      chk("idle_ready_load_ready", mon_load_ready, 1);
      tick();
    end

    for (int v = 0; v < 5; v++) begin
      use_b = vecs[v].use_b;
      load_word(vecs[v].d);
      cyc = 0;
      shift_bits(vecs[v].seq, vecs[v].par, vecs[v].stall_at, vecs[v].stall_len, 1'b0, cyc);
      finish_frame(vecs[v].cycles, cyc);
    end

    // Load offered while busy, then held into the first IDLE cycle.
    use_b = 1'b0;
    load_word(8'hA5);
    cyc = 0;
    shift_bits(8'b10100101, 1'b0, -1, 0, 1'b1, cyc);
    finish_frame(8, cyc);
    load_valid = 1'b0;
    d          = 8'h00;
    chk("chained_busy", mon_busy, 1);
    cyc = 0;
    shift_bits(8'b00111100, 1'b0, -1, 0, 1'b0, cyc);
    finish_frame(8, cyc);

    // Reset in the middle of a frame.
    load_word(8'hA5);
    for (int i = 0; i < 4; i++) begin
      chk("pre_reset_bits", mon_out, (i % 2 == 0) ? 1 : 0);
      tick();
    end
    reset_n_amisha = 1'b0;
    #1;
    chk("midrst_valid", mon_valid, 0);
    chk("midrst_load_ready", mon_load_ready, 1);
    chk("midrst_busy", mon_busy, 0);
    chk("midrst_out", mon_out, 0);
    chk("midrst_done", mon_done, 0);
    #3;
    reset_n_amisha = 1'b1;
    tick();
    chk("postrst_done", mon_done, 0);
    chk("postrst_valid", mon_valid, 0);
    load_word(8'hFF);
    cyc = 0;
    shift_bits(8'b11111111, 1'b0, -1, 0, 1'b0, cyc);
    finish_frame(8, cyc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/piso_serializer_amisha.md
Name: piso_serializer_amisha

Overview:
- Downstream stage of the 8-bit registered data path. Accepts one parallel word per frame through a valid/ready load port and shifts it out one bit per handshake on a serial valid/ready port.
- Sits between the parallel capture register and a serial link or bit-level consumer. The consumer can stall the block at any bit.

Parameters:
WIDTH, 8, parallel word width in bits (minimum 2)
MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first

Ports:
clk_amisha  input  1  clock; all state changes on the rising edge
reset_n_amisha  input  1  asynchronous reset, active-low
d_amisha  input  WIDTH  parallel word; sampled only on a load handshake
load_valid_amisha  input  1  upstream has a word on d_amisha
load_ready_amisha  output  1  block can accept a word (state IDLE)
ser_out_amisha  output  1  current serial bit
ser_valid_amisha  output  1  ser_out_amisha holds a valid bit
ser_ready_amisha  input  1  downstream accepts the current bit
busy_amisha  output  1  frame in progress (state != IDLE)
frame_done_amisha  output  1  one-cycle pulse after the last bit of a frame is accepted

Behaviour:
- Reset (reset_n_amisha low, asynchronous):
  - state = IDLE, shift register = 0, bit counter = 0.
  - ser_out_amisha = 0, ser_valid_amisha = 0, frame_done_amisha = 0, busy_amisha = 0, load_ready_amisha = 1.
- States: IDLE, SHIFT, and PARITY (PARITY exists only with the optional feature). Encoding comes from the package.
- load_ready_amisha = (state == IDLE), decoded combinationally.
- All other outputs are registered.
- Load: on load_valid_amisha & load_ready_amisha at a rising edge:
  - d_amisha is captured.
  - The counter is cleared and state moves to SHIFT.
  - On the next cycle ser_valid_amisha = 1 and ser_out_amisha = the first bit (per MSB_FIRST).
  - Load-to-first-bit latency is 1 cycle.
- Bit handshake: a bit is consumed on a rising edge with ser_valid_amisha & ser_ready_amisha. The next bit appears on the following cycle.
- Stall: while ser_ready_amisha = 0, ser_out_amisha and ser_valid_amisha hold their values indefinitely.
- End of frame: when bit WIDTH-1 (counter value WIDTH-1) is consumed:
  - state returns to IDLE and ser_valid_amisha drops to 0.
  - frame_done_amisha = 1 for exactly one cycle, in the first IDLE cycle.
- Throughput: at least WIDTH+1 cycles per frame with ser_ready_amisha held high.
- Back-to-back frames: no load is accepted in the same cycle as the last-bit handshake. A word offered during the final bit is accepted in the first IDLE cycle.
- load_valid_amisha while busy: ignored. d_amisha is not sampled and the shift register is unchanged.
- ser_ready_amisha while ser_valid_amisha = 0: ignored, no state change.
- Reset mid-frame: the frame is aborted immediately. Outputs take their reset values and no frame_done_amisha pulse is produced.
- Counter width is clog2(WIDTH). The counter never wraps inside a frame; it is cleared on load.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - After bit WIDTH-1 is consumed, state moves to PARITY instead of IDLE.
  - ser_valid_amisha stays 1 and ser_out_amisha = even parity (XOR of all WIDTH captured bits).
  - When that parity bit is consumed, state returns to IDLE and frame_done_amisha pulses one cycle later.
  - A frame is WIDTH+1 bits; minimum throughput is WIDTH+2 cycles.
- Not defined:
  - The PARITY state and parity logic are absent.
  - A frame is WIDTH bits, exactly as above.

Decomposition:
- Package piso_pkg_amisha holds:
  - state encoding constants: IDLE = 2'b00, SHIFT = 2'b01, PARITY = 2'b10;
  - the default WIDTH constant;
  - a clog2 function for counter sizing.
- Sub-module bit_cnt_amisha: a clearable, enabled up-counter with a terminal-count flag at WIDTH-1. It is instantiated once; the FSM and shift register stay in the top module.

Test Plan:
- Basic MSB-first frame:
  - Setup: WIDTH=8, MSB_FIRST=1, ser_ready_amisha held 1; load 8'hA5.
  - Response: ser_out_amisha = 1,0,1,0,0,1,0,1 on 8 consecutive cycles starting 1 cycle after the load handshake; frame_done_amisha pulses 1 cycle after the 8th bit; load_ready_amisha returns to 1.
- LSB-first frame:
  - Setup: MSB_FIRST=0; load 8'h01.
  - Response: bits 1,0,0,0,0,0,0,0.
- Stall:
  - Stimulus: load 8'hA5, then drop ser_ready_amisha for 3 cycles while bit index 3 is presented.
  - Response: ser_out_amisha = 0 and ser_valid_amisha = 1 held for those 3 cycles; the remaining bits follow unchanged; the frame is 3 cycles longer.
- Load while busy:
  - Stimulus: during an 8'hA5 frame, assert load_valid_amisha with 8'h3C for 2 cycles.
  - Response: load_ready_amisha = 0 throughout, and the 8'hA5 bit stream is uncorrupted. If load_valid_amisha is still high at frame end, 8'h3C is accepted in the first IDLE cycle.
- Reset mid-frame:
  - Stimulus: pull reset_n_amisha low after 4 bits of 8'hA5.
  - Response: ser_valid_amisha = 0 immediately, load_ready_amisha = 1, no frame_done_amisha pulse; a new load of 8'hFF then serializes eight 1s.
- Parity (PISO_PARITY_EN defined):
  - 8'hA5 gives a 9th bit of 0; 8'h07 gives a 9th bit of 1.
  - frame_done_amisha pulses only after the 9th bit is consumed.
